// File: rtl/addf_seq_wide_adder.sv
// addf_seq_wide_adder: multi-cycle wide add/sub, one WIDTH-bit ripple-carry chunk per cycle with valid/ready handshakes
module addf_seq_wide_adder #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_ci,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_co,
  output logic                   out_ovf
);
  localparam int N  = WIDTH * WORDS;
  localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] a_r, b_r;
  logic carry, c, last, accept;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ach, bch, s;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_ready && in_valid;
  assign last      = cnt == CW'(WORDS - 1);
  assign ach       = a_r[int'(cnt)*WIDTH +: WIDTH];
  assign bch       = b_r[int'(cnt)*WIDTH +: WIDTH];
  assign {c, s}    = {1'b0, ach} + {1'b0, bch} + {{WIDTH{1'b0}}, carry};
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = RUN;
    else if (state == RUN && last) state_nx = DONE;
    else if (out_valid && out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      out_sum <= '0;
      out_co  <= 1'b0;
      out_ovf <= 1'b0;
    end else if (accept) begin
      a_r   <= in_a;
      b_r   <= in_sub ? ~in_b : in_b;
      carry <= in_ci;
      cnt   <= '0;
    end else if (state == RUN) begin
      out_sum[int'(cnt)*WIDTH +: WIDTH] <= s;
      carry <= c;
      cnt   <= last ? '0 : cnt + 1'b1;
      if (last) begin
        out_co  <= c;
        out_ovf <= (ach[WIDTH-1] == bch[WIDTH-1]) && (s[WIDTH-1] != ach[WIDTH-1]);
      end
    end
  end
endmodule

// File: tb/tb_addf_seq_wide_adder.sv
// tb_addf_seq_wide_adder: directed and randomized checks of the sequential wide adder at WORDS=4 and WORDS=1
module tb_addf_seq_wide_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic iv4 = 1'b0, ci4 = 1'b0, sb4 = 1'b0, or4 = 1'b0;
  logic ir4, ov4, co4, of4;
  logic [63:0] a4 = '0, b4 = '0, s4;
  logic iv1 = 1'b0, ci1 = 1'b0, sb1 = 1'b0, or1 = 1'b0;
  logic ir1, ov1, co1, of1;
  logic [15:0] a1 = '0, b1 = '0, s1;
  addf_seq_wide_adder #(.WIDTH(16), .WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_ci(ci4), .in_sub(sb4), .out_valid(ov4), .out_ready(or4), .out_sum(s4),
    .out_co(co4), .out_ovf(of4));
  addf_seq_wide_adder #(.WIDTH(16), .WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1),
    .in_ci(ci1), .in_sub(sb1), .out_valid(ov1), .out_ready(or1), .out_sum(s1),
    .out_co(co1), .out_ovf(of1));
  function automatic logic [65:0] ref64(input logic [63:0] a, b, input logic ci, sub);
    logic [63:0] bb;
    logic [64:0] r;
    bb = sub ? ~b : b;
    r = {1'b0, a} + {1'b0, bb} + {64'b0, ci};
    return {(a[63] == bb[63]) && (r[63] != a[63]), r};
  endfunction
  function automatic logic [17:0] ref16(input logic [15:0] a, b, input logic ci, sub);
    logic [15:0] bb;
    logic [16:0] r;
    bb = sub ? ~b : b;
    r = {1'b0, a} + {1'b0, bb} + {16'b0, ci};
    return {(a[15] == bb[15]) && (r[15] != a[15]), r};
  endfunction
  task automatic op4(input logic [63:0] a, b, input logic ci, sub, input int gap, hold,
                     output logic [65:0] res, output int lat);
    repeat (gap) @(negedge clk);
    iv4 = 1'b1; a4 = a; b4 = b; ci4 = ci; sb4 = sub;
    @(negedge clk);
    iv4 = 1'b0; a4 = {$urandom, $urandom}; b4 = {$urandom, $urandom}; ci4 = ~ci; sb4 = ~sub;
    lat = 0;
    while (!ov4 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    repeat (hold) @(negedge clk);
    res = {of4, co4, s4};
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
  endtask
  task automatic op1(input logic [15:0] a, b, input logic ci, sub, input int gap, hold,
                     output logic [17:0] res, output int lat);
    repeat (gap) @(negedge clk);
    iv1 = 1'b1; a1 = a; b1 = b; ci1 = ci; sb1 = sub;
    @(negedge clk);
    iv1 = 1'b0; a1 = 16'($urandom); b1 = 16'($urandom); ci1 = ~ci; sb1 = ~sub;
    lat = 0;
    while (!ov1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    repeat (hold) @(negedge clk);
    res = {of1, co1, s1};
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs4: ready=%b valid=%b required ready=1 valid=0", ir4, ov4);
    end
    checks++;
    if ({of4, co4, s4} !== 66'h0) begin
      errors++;
      $display("FAIL reset_out4: ovf=%b co=%b sum=%h required all zero", of4, co4, s4);
    end
    checks++;
    if ({ir1, ov1, of1, co1, s1} !== {1'b1, 19'h0}) begin
      errors++;
      $display("FAIL reset_1: ready=%b valid=%b ovf=%b co=%b sum=%h required 1,0,0,0,0",
               ir1, ov1, of1, co1, s1);
    end
  endtask
  task automatic test_directed();
    logic [65:0] r;
    logic [17:0] r1;
    int lat;
    op4(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, 0, r, lat);
    checks++;
    if (r !== {1'b0, 1'b1, 64'h0} || lat != 4) begin
      errors++;
      $display("FAIL allones_plus_ci: got %h lat %0d required %h lat 4", r, lat, {1'b0, 1'b1, 64'h0});
    end
    op4(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1, 0, r, lat);
    checks++;
    if (r !== {1'b1, 1'b0, 64'h8000_0000_0000_0000}) begin
      errors++;
      $display("FAIL pos_overflow: got %h required %h", r, {1'b1, 1'b0, 64'h8000_0000_0000_0000});
    end
    op4(64'd5, 64'd7, 1'b1, 1'b1, 0, 2, r, lat);
    checks++;
    if (r !== {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      errors++;
      $display("FAIL sub_5_7: got %h required %h", r, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    end
    op4(64'd7, 64'd5, 1'b1, 1'b1, 0, 0, r, lat);
    checks++;
    if (r !== {1'b0, 1'b1, 64'd2}) begin
      errors++;
      $display("FAIL sub_7_5: got %h required %h", r, {1'b0, 1'b1, 64'd2});
    end
    op1(16'hFFFF, 16'h0, 1'b1, 1'b0, 0, 0, r1, lat);
    checks++;
    if (r1 !== {1'b0, 1'b1, 16'h0} || lat != 1) begin
      errors++;
      $display("FAIL w1_allones: got %h lat %0d required %h lat 1", r1, lat, {1'b0, 1'b1, 16'h0});
    end
    op1(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0, r1, lat);
    checks++;
    if (r1 !== {1'b1, 1'b0, 16'h8000}) begin
      errors++;
      $display("FAIL w1_overflow: got %h required %h", r1, {1'b1, 1'b0, 16'h8000});
    end
  endtask
  task automatic test_backpressure();
    int lat;
    iv4 = 1'b1; a4 = 64'd3; b4 = 64'd4; ci4 = 1'b0; sb4 = 1'b0;
    @(negedge clk);
    iv4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      iv4 = ~iv4; a4 = {$urandom, $urandom}; b4 = {$urandom, $urandom}; ci4 = ~ci4; sb4 = ~sb4;
      checks++;
      if ({of4, co4, s4} !== {2'b00, 64'd7} || ov4 !== 1'b1 || ir4 !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: sum=%h co=%b ovf=%b valid=%b ready=%b required sum=7 co=0 ovf=0 valid=1 ready=0",
                 i, s4, co4, of4, ov4, ir4);
      end
      @(negedge clk);
    end
    iv4 = 1'b0; or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    checks++;
    if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
      errors++;
      $display("FAIL release: valid=%b ready=%b required valid=0 ready=1", ov4, ir4);
    end
  endtask
  task automatic test_reset_mid_run();
    logic [65:0] r;
    int lat;
    iv4 = 1'b1; a4 = 64'h1111_2222_3333_4444; b4 = 64'h1; ci4 = 1'b0; sb4 = 1'b0;
    @(negedge clk);
    iv4 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0 || s4 !== 64'h0) begin
      errors++;
      $display("FAIL mid_run_reset: ready=%b valid=%b sum=%h required ready=1 valid=0 sum=0", ir4, ov4, s4);
    end
    op4(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 0, 0, r, lat);
    checks++;
    if (r !== {2'b00, 64'h2222_2222_2222_2211} || lat != 4) begin
      errors++;
      $display("FAIL after_reset_op: got %h lat %0d required %h lat 4", r, lat, {2'b00, 64'h2222_2222_2222_2211});
    end
  endtask
  task automatic test_random();
    logic [63:0] a, b;
    logic ci, sub;
    logic [65:0] r;
    logic [17:0] r1;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; ci = 1'($urandom); sub = 1'($urandom);
      op4(a, b, ci, sub, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r, lat);
      checks++;
      if (r !== ref64(a, b, ci, sub) || lat != 4) begin
        errors++;
        $display("FAIL rand4_%0d: a=%h b=%h ci=%b sub=%b got %h lat %0d required %h lat 4",
                 i, a, b, ci, sub, r, lat, ref64(a, b, ci, sub));
      end
    end
    for (int i = 0; i < 1000; i++) begin
      a[15:0] = 16'($urandom); b[15:0] = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      op1(a[15:0], b[15:0], ci, sub, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r1, lat);
      checks++;
      if (r1 !== ref16(a[15:0], b[15:0], ci, sub) || lat != 1) begin
        errors++;
        $display("FAIL rand1_%0d: a=%h b=%h ci=%b sub=%b got %h lat %0d required %h lat 1",
                 i, a[15:0], b[15:0], ci, sub, r1, lat, ref16(a[15:0], b[15:0], ci, sub));
      end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
